// File: rtl/wb_stage.sv
// Write-back stage: register-file write, CP0 (Status/Cause/EPC/BadVAddr[/Count/Compare]), exception/ERET flush.
// Optional timer interrupt (Count/Compare driving Cause.TI) is built only when WS_TIMER_INT_EN is defined.
module wb_stage #(
  parameter logic [31:0] EX_ENTRY = 32'hbfc00380,
  localparam int MS_TO_WS_BUS_WD = 150
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  output logic [37:0]                ws_to_rf_bus,
  output logic                       ex_from_ws,
  output logic [31:0]                ex_pc,
  input  logic [5:0]                 ext_int,
  output logic                       int_pending,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  // Handshake: an instruction moves in on a cycle where ms_to_ws_valid && ws_allowin;
  // this stage always completes in one cycle, so ws_allowin is permanently 1.
  logic                       ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] bus_r;

  assign ws_allowin = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid && !ex_from_ws;
    end
  end

  always_ff @(posedge clk) begin
    if (ms_to_ws_valid && ws_allowin) begin
      bus_r <= ms_to_ws_bus;
    end
  end

  logic        inst_addr_ex, eret, bd, mtc0_we, res_from_cp0, ex, gr_we;
  logic [31:0] rt_value, alu_result, final_result, pc;
  logic [4:0]  cp0_addr, excode, dest;

  assign {inst_addr_ex, rt_value, eret, bd, mtc0_we, cp0_addr, res_from_cp0,
          alu_result, ex, excode, gr_we, dest, final_result, pc} = bus_r;

  logic ws_ex, ws_eret, mtc0_wr, compare_wr, ti_set;
  assign ws_ex      = ws_valid && ex;
  assign ws_eret    = ws_valid && eret && !ex;
  assign mtc0_wr    = ws_valid && mtc0_we && !ex;
  assign compare_wr = mtc0_wr && (cp0_addr == 5'd11);

  logic [7:0]  status_im;
  logic        status_exl, status_ie;
  logic        cause_bd, cause_ti;
  logic [1:0]  cause_ip_sw;
  logic [5:0]  cause_ip_hw;
  logic [4:0]  cause_excode;
  logic [31:0] epc, badvaddr, count_rd, compare_rd;
  logic [7:0]  cause_ip;

`ifdef WS_TIMER_INT_EN
  logic        tick;
  logic [31:0] count, compare;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick  <= 1'b0;
      count <= 32'd0;
    end else begin
      tick <= ~tick;
      if (mtc0_wr && (cp0_addr == 5'd9)) begin
        count <= rt_value;
      end else if (tick) begin
        count <= count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (compare_wr) begin
      compare <= rt_value;
    end
  end

  assign count_rd   = count;
  assign compare_rd = compare;
  assign ti_set     = (count == compare);
`else
  assign count_rd   = 32'd0;
  assign compare_rd = 32'd0;
  assign ti_set     = 1'b0;
`endif

  // Exception update is applied last so it overrides any MTC0/ERET effect on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_im    <= 8'd0;
      status_exl   <= 1'b0;
      status_ie    <= 1'b0;
      cause_bd     <= 1'b0;
      cause_ti     <= 1'b0;
      cause_ip_sw  <= 2'd0;
      cause_ip_hw  <= 6'd0;
      cause_excode <= 5'd0;
    end else begin
      cause_ip_hw <= ext_int;
      if (mtc0_wr && (cp0_addr == 5'd12)) begin
        status_im  <= rt_value[15:8];
        status_exl <= rt_value[1];
        status_ie  <= rt_value[0];
      end
      if (mtc0_wr && (cp0_addr == 5'd13)) begin
        cause_ip_sw <= rt_value[9:8];
      end
      if (compare_wr) begin
        cause_ti <= 1'b0;
      end else if (ti_set) begin
        cause_ti <= 1'b1;
      end
      if (ws_eret) begin
        status_exl <= 1'b0;
      end
      if (ws_ex) begin
        status_exl   <= 1'b1;
        cause_excode <= excode;
        if (!status_exl) begin
          cause_bd <= bd;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ws_ex) begin
      if (!status_exl) begin
        epc <= bd ? (pc - 32'd4) : pc;
      end
    end else if (mtc0_wr && (cp0_addr == 5'd14)) begin
      epc <= rt_value;
    end
    if (ws_ex && ((excode == 5'd4) || (excode == 5'd5))) begin
      badvaddr <= inst_addr_ex ? pc : alu_result;
    end
  end

  assign cause_ip = {cause_ip_hw[5] | cause_ti, cause_ip_hw[4:0], cause_ip_sw};

  logic [31:0] cp0_rdata;
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      5'd8:    cp0_rdata = badvaddr;
      5'd9:    cp0_rdata = count_rd;
      5'd11:   cp0_rdata = compare_rd;
      5'd12:   cp0_rdata = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
      5'd13:   cp0_rdata = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_excode, 2'd0};
      5'd14:   cp0_rdata = epc;
      default: cp0_rdata = 32'd0;
    endcase
  end

  logic        rf_we;
  logic [31:0] rf_wdata;
  assign rf_we    = ws_valid && gr_we && !ex;
  assign rf_wdata = res_from_cp0 ? cp0_rdata : final_result;

  assign ws_to_rf_bus = {rf_we, dest, rf_wdata};
  assign ex_from_ws   = ws_valid && (ex || eret);
  assign ex_pc        = (eret && !ex) ? epc : EX_ENTRY;
  assign int_pending  = (|(cause_ip & status_im)) && status_ie && !status_exl;

  assign debug_wb_pc       = pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = dest;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed instructions push expected write-backs/flush targets into queues,
// a negedge monitor pops and compares whenever the stage writes the register file or flushes.
module tb_wb_stage;
  localparam logic [31:0] EX_ENTRY = 32'hbfc00380;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ms_to_ws_valid = 1'b0;
  logic [149:0] ms_to_ws_bus = '0;
  logic         ws_allowin;
  logic [37:0]  ws_to_rf_bus;
  logic         ex_from_ws;
  logic [31:0]  ex_pc;
  logic [5:0]   ext_int = 6'd0;
  logic         int_pending;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] pc_n = 32'hbfc01000;

  logic [68:0] exp_wb_q[$];
  logic [31:0] exp_ex_q[$];

  wb_stage #(.EX_ENTRY(EX_ENTRY)) dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ws_allowin(ws_allowin), .ws_to_rf_bus(ws_to_rf_bus),
    .ex_from_ws(ex_from_ws), .ex_pc(ex_pc),
    .ext_int(ext_int), .int_pending(int_pending),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [68:0] got, input logic [68:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [149:0] mk(input logic iae, input logic [31:0] rt, input logic eret,
                                      input logic bd, input logic mtc0, input logic [4:0] addr,
                                      input logic rfc0, input logic [31:0] alu, input logic ex,
                                      input logic [4:0] code, input logic gr_we, input logic [4:0] dest,
                                      input logic [31:0] res, input logic [31:0] pc);
    return {iae, rt, eret, bd, mtc0, addr, rfc0, alu, ex, code, gr_we, dest, res, pc};
  endfunction

  // driver tasks: one instruction, then a bubble; returns while the instruction sits in the stage
  task automatic send(input logic [149:0] b);
    @(posedge clk); #1;
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = b;
    @(posedge clk); #1;
    ms_to_ws_valid = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic alu_op(input logic [4:0] dest, input logic [31:0] val, input logic [31:0] pc);
    exp_wb_q.push_back({dest, val, pc});
    send(mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, val, 1'b0, 5'd0, 1'b1, dest, val, pc));
  endtask

  task automatic mfc0(input logic [4:0] addr, input logic [31:0] expv);
    exp_wb_q.push_back({5'd7, expv, pc_n});
    send(mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, addr, 1'b1, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hdeadbeef, pc_n));
    pc_n = pc_n + 32'd4;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] val);
    send(mk(1'b0, val, 1'b0, 1'b0, 1'b1, addr, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, pc_n));
    pc_n = pc_n + 32'd4;
  endtask

  task automatic raise(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                       input logic iae, input logic [31:0] alu);
    exp_ex_q.push_back(EX_ENTRY);
    send(mk(iae, 32'd0, 1'b0, bd, 1'b0, 5'd0, 1'b0, alu, 1'b1, code, 1'b1, 5'd9, 32'h5555, pc));
  endtask

  task automatic eret_op(input logic [31:0] target);
    exp_ex_q.push_back(target);
    send(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, pc_n));
    pc_n = pc_n + 32'd4;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (ws_to_rf_bus[37]) begin
        if (exp_wb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected got pc=%h wnum=%0d wdata=%h expected no write",
                   debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata);
        end else begin
          logic [68:0] e;
          e = exp_wb_q.pop_front();
          chk("wb_bus", {ws_to_rf_bus[36:0], debug_wb_pc}, e);
          chk("wb_debug", {debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata},
              {4'hf, e[68:32]});
        end
      end
      if (ex_from_ws) begin
        if (exp_ex_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ex_unexpected got ex_pc=%h expected no flush", ex_pc);
        end else begin
          chk("ex_pc", {37'd0, ex_pc}, {37'd0, exp_ex_q.pop_front()});
          chk("ex_no_rf_we", {68'd0, ws_to_rf_bus[37]}, 69'd0);
        end
      end
    end
  end

  int c0;
  int waited;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_allowin", {68'd0, ws_allowin}, 69'd1);
    chk("rst_ex_from_ws", {68'd0, ex_from_ws}, 69'd0);
    chk("rst_rf_we", {68'd0, ws_to_rf_bus[37]}, 69'd0);
    chk("rst_int_pending", {68'd0, int_pending}, 69'd0);
    chk("rst_debug_wen", {65'd0, debug_wb_rf_wen}, 69'd0);
    @(negedge clk);
    reset = 1'b1;

    mtc0(5'd11, 32'hffff_fff0);
    alu_op(5'd5, 32'h0000_1234, 32'hbfc00000);
    alu_op(5'd31, 32'hffff_ffff, 32'hbfc00004);
    mfc0(5'd12, 32'h0040_0000);
    mfc0(5'd13, 32'h0000_0000);

    // first exception in delay slot, EXL=0
    raise(5'h08, 32'hbfc00100, 1'b1, 1'b0, 32'd0);
    mfc0(5'd14, 32'hbfc000fc);
    mfc0(5'd13, 32'h8000_0020);
    mfc0(5'd12, 32'h0040_0002);

    // nested exceptions with EXL=1: EPC/BD hold, ExcCode and BadVAddr update
    raise(5'h04, 32'hbfc00200, 1'b0, 1'b0, 32'h0000_1001);
    mfc0(5'd14, 32'hbfc000fc);
    mfc0(5'd13, 32'h8000_0010);
    mfc0(5'd8, 32'h0000_1001);
    raise(5'h05, 32'hbfc00208, 1'b0, 1'b1, 32'h0000_2002);
    mfc0(5'd8, 32'hbfc00208);
    mfc0(5'd13, 32'h8000_0014);

    // MTC0 EPC then ERET
    mtc0(5'd14, 32'hbfc00400);
    eret_op(32'hbfc00400);
    mfc0(5'd12, 32'h0040_0000);

    // Status/Cause writable fields and interrupt pending
    mtc0(5'd12, 32'h0000_ff01);
    mfc0(5'd12, 32'h0040_ff01);
    mtc0(5'd13, 32'hffff_ffff);
    mfc0(5'd13, 32'h8000_0314);
    chk("int_pending_sw", {68'd0, int_pending}, 69'd1);
    mtc0(5'd13, 32'h0000_0000);
    settle();
    chk("int_pending_sw_clr", {68'd0, int_pending}, 69'd0);
    mtc0(5'd12, 32'h0000_0401);
    ext_int = 6'h01;
    settle();
    settle();
    chk("int_pending_hw", {68'd0, int_pending}, 69'd1);
    mfc0(5'd13, 32'h8000_0414);
    ext_int = 6'h00;
    settle();
    settle();
    chk("int_pending_hw_clr", {68'd0, int_pending}, 69'd0);
    mtc0(5'd12, 32'h0000_0000);
    mfc0(5'd3, 32'h0000_0000);
`ifdef WS_TIMER_INT_EN
    mfc0(5'd11, 32'hffff_fff0);
`else
    mfc0(5'd11, 32'h0000_0000);
    mfc0(5'd9, 32'h0000_0000);
`endif

    // exception takes priority over an MTC0 in the same instruction
    exp_ex_q.push_back(EX_ENTRY);
    send(mk(1'b0, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 5'd14, 1'b0, 32'd0, 1'b1, 5'h0a, 1'b0, 5'd0,
            32'd0, 32'hbfc00300));
    mfc0(5'd14, 32'hbfc00300);
    mfc0(5'd13, 32'h0000_0028);

    // reset asserted during an ERET flush
    eret_op(32'hbfc00300);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_flush_ex", {68'd0, ex_from_ws}, 69'd0);
    chk("rst_mid_flush_int", {68'd0, int_pending}, 69'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    c0 = cyc;
    mfc0(5'd12, 32'h0040_0000);
    mfc0(5'd13, 32'h0000_0000);
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd10);

`ifdef WS_TIMER_INT_EN
    waited = 0;
    while (!int_pending && waited < 60) begin
      settle();
      waited++;
    end
    chk("timer_fire_cycle", {68'd0, (cyc - c0 >= 19) && (cyc - c0 <= 23)}, 69'd1);
    mfc0(5'd13, 32'h4000_8000);
    mtc0(5'd11, 32'd1000);
    settle();
    chk("timer_clr_int", {68'd0, int_pending}, 69'd0);
    mfc0(5'd13, 32'h0000_0000);
`else
    repeat (40) settle();
    chk("no_timer_int", {68'd0, int_pending}, 69'd0);
    mfc0(5'd13, 32'h0000_0000);
    mfc0(5'd9, 32'h0000_0000);
`endif

    settle();
    settle();
    chk("queues_drained", {37'd0, exp_wb_q.size() + exp_ex_q.size()}, 69'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
